// File: rtl/tlb_op_unit.sv
// Sequencer for TLBP/TLBR/TLBWI/TLBWR: drives TLB write strobes, maintains Random/Wired,
// and returns probe/read results to CP0. Optional FLUSH state after writes: TLB_OP_FLUSH_EN.
module tlb_op_unit #(
    parameter int TLB_NUM = 16,
    parameter int IDXW    = $clog2(TLB_NUM)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid_i,
    input  logic [1:0]      op_code_i,
    output logic            op_ready_o,
    output logic            op_done_o,
    output logic            flush_o,
    input  logic [31:0]     cp0_index_i,
    input  logic            wired_we_i,
    input  logic [IDXW-1:0] wired_wdata_i,
    output logic [31:0]     random_o,
    output logic            tlb_write_index_o,
    output logic            tlb_write_random_o,
    input  logic [159:0]    tlb_cp0_bus_i,
    output logic            index_we_o,
    output logic [31:0]     index_wdata_o,
    output logic            entry_we_o,
    output logic [31:0]     entryhi_o,
    output logic [31:0]     entrylo0_o,
    output logic [31:0]     entrylo1_o,
    output logic [31:0]     pagemask_o
);

    localparam logic [IDXW-1:0] RANDOM_TOP = IDXW'(TLB_NUM - 1);

    typedef enum logic [1:0] {
        OP_TLBP  = 2'd0,
        OP_TLBR  = 2'd1,
        OP_TLBWI = 2'd2,
        OP_TLBWR = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_EXEC  = 2'd1,
        S_DONE  = 2'd2,
        S_FLUSH = 2'd3
    } state_e;

    state_e          state;
    op_e             op;
    logic [IDXW-1:0] random;
    logic [IDXW-1:0] wired;
    logic            exec_wr;

    // The TLB consumes Index directly from CP0; this unit only sequences the strobe.
    logic unused_cp0_index;
    assign unused_cp0_index = ^cp0_index_i;

    assign exec_wr  = (state == S_EXEC) && (op == OP_TLBWR);
    assign random_o = 32'(random);

    // NOTE: every register here, including the write-back data, has a reset value so the
    // outputs are defined immediately after rst falls, even mid-operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= S_IDLE;
            op                 <= OP_TLBP;
            op_ready_o         <= 1'b1;
            op_done_o          <= 1'b0;
            tlb_write_index_o  <= 1'b0;
            tlb_write_random_o <= 1'b0;
            index_we_o         <= 1'b0;
            entry_we_o         <= 1'b0;
            index_wdata_o      <= '0;
            entryhi_o          <= '0;
            entrylo0_o         <= '0;
            entrylo1_o         <= '0;
            pagemask_o         <= '0;
`ifdef TLB_OP_FLUSH_EN
            flush_o            <= 1'b0;
`endif
        end else begin
            // NOTE: strobes default low at the top so each one is a single-cycle pulse;
            // non-blocking assignment lets later branches override without ordering races.
            op_done_o          <= 1'b0;
            tlb_write_index_o  <= 1'b0;
            tlb_write_random_o <= 1'b0;
            index_we_o         <= 1'b0;
            entry_we_o         <= 1'b0;
`ifdef TLB_OP_FLUSH_EN
            flush_o            <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (op_valid_i) begin
                        op                 <= op_e'(op_code_i);
                        state              <= S_EXEC;
                        op_ready_o         <= 1'b0;
                        tlb_write_index_o  <= (op_code_i == OP_TLBWI);
                        tlb_write_random_o <= (op_code_i == OP_TLBWR);
                    end
                end
                S_EXEC: begin
                    state      <= S_DONE;
                    op_done_o  <= 1'b1;
                    index_we_o <= (op == OP_TLBP);
                    entry_we_o <= (op == OP_TLBR);
                    // Captured before the TLB write edge, so a probe/read sees old contents.
                    if (op == OP_TLBP) begin
                        index_wdata_o <= tlb_cp0_bus_i[31:0];
                    end
                    if (op == OP_TLBR) begin
                        entrylo1_o <= tlb_cp0_bus_i[159:128];
                        entrylo0_o <= tlb_cp0_bus_i[127:96];
                        entryhi_o  <= tlb_cp0_bus_i[95:64];
                        pagemask_o <= tlb_cp0_bus_i[63:32];
                    end
                end
                S_DONE: begin
`ifdef TLB_OP_FLUSH_EN
                    if (op == OP_TLBWI || op == OP_TLBWR) begin
                        state   <= S_FLUSH;
                        flush_o <= 1'b1;
                    end else begin
                        state      <= S_IDLE;
                        op_ready_o <= 1'b1;
                    end
`else
                    state      <= S_IDLE;
                    op_ready_o <= 1'b1;
`endif
                end
                default: begin
                    state      <= S_IDLE;
                    op_ready_o <= 1'b1;
                end
            endcase
        end
    end

`ifndef TLB_OP_FLUSH_EN
    assign flush_o = 1'b0;
`endif

    // Random counts down to Wired and wraps to the top; it freezes while TLBWR uses it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random <= RANDOM_TOP;
            wired  <= '0;
        end else begin
            if (wired_we_i) begin
                wired <= wired_wdata_i;
            end
            if (wired_we_i) begin
                random <= RANDOM_TOP;
            end else if (exec_wr) begin
                random <= random;
            end else if (random == wired) begin
                random <= RANDOM_TOP;
            end else begin
                random <= random - IDXW'(1);
            end
        end
    end

endmodule

// File: tb/tb_tlb_op_unit.sv
// Directed bench for tlb_op_unit with a cycle-level reference model and per-cycle compare.
module tb_tlb_op_unit;

    localparam int N    = 16;
    localparam int IDXW = 4;

    logic            clk;
    logic            rst;
    logic            op_valid;
    logic [1:0]      op_code;
    logic            op_ready;
    logic            op_done;
    logic            flush;
    logic [31:0]     cp0_index;
    logic            wired_we;
    logic [IDXW-1:0] wired_wdata;
    logic [31:0]     random_val;
    logic            tlb_write_index;
    logic            tlb_write_random;
    logic [159:0]    tlb_cp0_bus;
    logic            index_we;
    logic [31:0]     index_wdata;
    logic            entry_we;
    logic [31:0]     entryhi;
    logic [31:0]     entrylo0;
    logic [31:0]     entrylo1;
    logic [31:0]     pagemask;

    int vectors     = 0;
    int miscompares = 0;

    tlb_op_unit #(.TLB_NUM(N), .IDXW(IDXW)) dut (
        .clk                (clk),
        .rst                (rst),
        .op_valid_i         (op_valid),
        .op_code_i          (op_code),
        .op_ready_o         (op_ready),
        .op_done_o          (op_done),
        .flush_o            (flush),
        .cp0_index_i        (cp0_index),
        .wired_we_i         (wired_we),
        .wired_wdata_i      (wired_wdata),
        .random_o           (random_val),
        .tlb_write_index_o  (tlb_write_index),
        .tlb_write_random_o (tlb_write_random),
        .tlb_cp0_bus_i      (tlb_cp0_bus),
        .index_we_o         (index_we),
        .index_wdata_o      (index_wdata),
        .entry_we_o         (entry_we),
        .entryhi_o          (entryhi),
        .entrylo0_o         (entrylo0),
        .entrylo1_o         (entrylo1),
        .pagemask_o         (pagemask)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_age counts cycles since acceptance (0 = waiting for a request).
    int          m_random, m_wired, m_age, m_op;
    logic [31:0] m_idx, m_hi, m_lo0, m_lo1, m_pm;
    bit          flush_cfg;

    initial begin
`ifdef TLB_OP_FLUSH_EN
        flush_cfg = 1'b1;
`else
        flush_cfg = 1'b0;
`endif
    end

    task automatic m_reset();
        m_random = N - 1;
        m_wired  = 0;
        m_age    = 0;
        m_op     = 0;
        m_idx    = '0;
        m_hi     = '0;
        m_lo0    = '0;
        m_lo1    = '0;
        m_pm     = '0;
    endtask

    task automatic m_step();
        int next_random;
        if (wired_we)                      next_random = N - 1;
        else if (m_age == 1 && m_op == 3)  next_random = m_random;
        else if (m_random == m_wired)      next_random = N - 1;
        else                               next_random = m_random - 1;
        if (m_age == 1 && m_op == 0) m_idx = tlb_cp0_bus[31:0];
        if (m_age == 1 && m_op == 1) begin
            m_lo1 = tlb_cp0_bus[159:128];
            m_lo0 = tlb_cp0_bus[127:96];
            m_hi  = tlb_cp0_bus[95:64];
            m_pm  = tlb_cp0_bus[63:32];
        end
        case (m_age)
            0: if (op_valid) begin m_age = 1; m_op = int'(op_code); end
            1: m_age = 2;
            2: m_age = (flush_cfg && m_op >= 2) ? 3 : 0;
            default: m_age = 0;
        endcase
        m_random = next_random;
        if (wired_we) m_wired = int'(wired_wdata);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) m_reset();
            else      m_step();
        end
    end

    always @(negedge clk) begin
        check("ready",     32'(op_ready),         32'(m_age == 0));
        check("done",      32'(op_done),          32'(m_age == 2));
        check("flush",     32'(flush),            32'(m_age == 3));
        check("twi",       32'(tlb_write_index),  32'(m_age == 1 && m_op == 2));
        check("twr",       32'(tlb_write_random), 32'(m_age == 1 && m_op == 3));
        check("index_we",  32'(index_we),         32'(m_age == 2 && m_op == 0));
        check("entry_we",  32'(entry_we),         32'(m_age == 2 && m_op == 1));
        check("random",    random_val,            32'(m_random));
        check("index_wd",  index_wdata,           m_idx);
        check("entryhi",   entryhi,               m_hi);
        check("entrylo0",  entrylo0,              m_lo0);
        check("entrylo1",  entrylo1,              m_lo1);
        check("pagemask",  pagemask,              m_pm);
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!op_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", 32'(op_ready), 32'd1);
    endtask

    task automatic wait_random(input int v);
        int n = 0;
        while (random_val != 32'(v) && n < 60) begin
            @(negedge clk);
            n++;
        end
        check("wait_random", random_val, 32'(v));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b0;
        op_valid    = 1'b0;
        op_code     = 2'd0;
        cp0_index   = 32'd3;
        wired_we    = 1'b0;
        wired_wdata = '0;
        tlb_cp0_bus = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_random", random_val, 32'd15);
        check("rst_ready",  32'(op_ready), 32'd1);

        // Free-running Random with Wired = 0: 15 down to 0, then wrap to 15.
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 18; i++) begin
            #1;
            check("rand_seq", random_val, (i < 16) ? 32'(15 - i) : 32'(31 - i));
            check("rand_seq_ready", 32'(op_ready), 32'd1);
            @(negedge clk);
        end

        // Wired = 4 written while Random = 2.
        wait_random(2);
        wired_we    = 1'b1;
        wired_wdata = 4'd4;
        @(negedge clk);
        wired_we = 1'b0;
        #1;
        check("wired_reload", random_val, 32'd15);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            #1;
            check("wired_seq", random_val, (k < 12) ? 32'(15 - k) : 32'd15);
        end

        // TLBWR accepted on the edge where Random goes 10 -> 9.
        wait_random(10);
        op_valid = 1'b1;
        op_code  = 2'd3;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("twr_exec",   32'(tlb_write_random), 32'd1);
        check("twr_slot",   random_val, 32'd9);
        check("twr_no_twi", 32'(tlb_write_index), 32'd0);
        @(negedge clk);
        #1;
        check("twr_pulse_end", 32'(tlb_write_random), 32'd0);
        check("twr_done",      32'(op_done), 32'd1);
        check("twr_hold",      random_val, 32'd9);
        @(negedge clk);
        #1;
        check("twr_flush", 32'(flush), 32'(flush_cfg));

        // TLBP miss.
        wait_ready();
        op_valid    = 1'b1;
        op_code     = 2'd0;
        tlb_cp0_bus = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 32'h80000000};
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("tlbp_no_twi", 32'(tlb_write_index), 32'd0);
        check("tlbp_no_twr", 32'(tlb_write_random), 32'd0);
        @(negedge clk);
        #1;
        check("tlbp_we",    32'(index_we), 32'd1);
        check("tlbp_data",  index_wdata, 32'h80000000);
        check("tlbp_done",  32'(op_done), 32'd1);
        tlb_cp0_bus[31:0] = 32'h00000005;
        @(negedge clk);
        #1;
        check("tlbp_stable", index_wdata, 32'h80000000);
        check("tlbp_we_end", 32'(index_we), 32'd0);

        // TLBR with the request held high across the busy period.
        wait_ready();
        op_valid    = 1'b1;
        op_code     = 2'd1;
        tlb_cp0_bus = {32'h0BADF00D, 32'h00012345, 32'hABCDE012, 32'h00001800, 32'h00000007};
        @(negedge clk);
        #1;
        check("tlbr_busy", 32'(op_ready), 32'd0);
        @(negedge clk);
        #1;
        check("tlbr_we",       32'(entry_we), 32'd1);
        check("tlbr_lo0",      entrylo0, 32'h00012345);
        check("tlbr_hi",       entryhi, 32'hABCDE012);
        check("tlbr_lo1",      entrylo1, 32'h0BADF00D);
        check("tlbr_pm",       pagemask, 32'h00001800);
        check("tlbr_no_index", 32'(index_we), 32'd0);
        @(negedge clk);
        #1;
        check("tlbr_idle", 32'(op_ready), 32'd1);
        @(negedge clk);
        #1;
        check("tlbr_reaccept", 32'(op_ready), 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        #1;
        check("tlbr2_done", 32'(op_done), 32'd1);

        // Reset asserted during EXEC of TLBWI.
        wait_ready();
        op_valid = 1'b1;
        op_code  = 2'd2;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        check("twi_exec", 32'(tlb_write_index), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("twi_drop",   32'(tlb_write_index), 32'd0);
        check("twi_nodone", 32'(op_done), 32'd0);
        check("twi_ready",  32'(op_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post_rst_random", random_val, 32'd15);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("post_rst_nodone", 32'(op_done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
